// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts WAIT cycles without read data and flags the cycle the limit is reached.
module fetch_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);
  logic [7:0] r_cnt;
  assign o_hit = i_inc && (r_cnt == 8'(LIMIT - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 8'd1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: req/gnt/rvalid fetch sequencer with one-entry IF/ID buffer and delay-slot-safe redirects.
// Optional FETCH_TIMEOUT_EN adds a WAIT timeout that delivers a NOP and sets a sticky error.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        redirect_i,
  input  logic        pipe_stall_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_gnt_i,
  input  logic        im_rvalid_i,
  input  logic [31:0] im_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        pc_hold_o,
  output logic        pc_load_o,
  output logic        redirect_ack_o,
  output logic        fetch_err_o
);
  state_t      r_state;
  logic [31:0] r_instr, r_pc;
  logic        r_valid;
  logic        w_gnt, w_to;
  logic [1:0]  w_unused_pc;
  assign w_unused_pc    = pc_in[1:0];
  assign w_gnt          = (r_state == REQ) && im_gnt_i;
  assign im_req_o       = (r_state == REQ);
  assign im_addr_o      = {pc_in[31:2], 2'b00};
  // Redirect waits for the delay-slot grant so the slot is always fetched first.
  assign redirect_ack_o = redirect_i && ((r_state == WAIT) || (r_state == HOLD) || w_gnt);
  assign pc_load_o      = redirect_ack_o;
  assign pc_hold_o      = !(w_gnt || redirect_ack_o);
  assign instr_o        = r_instr;
  assign pc_o           = r_pc;
  assign instr_valid_o  = r_valid;
`ifdef FETCH_TIMEOUT_EN
  logic r_err;
  fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_gnt),
    .i_inc ((r_state == WAIT) && !im_rvalid_i),
    .o_hit (w_to)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_err <= 1'b0;
    else if (w_to) r_err <= 1'b1;
  assign fetch_err_o = r_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_to        = 1'b0;
  assign fetch_err_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_instr <= NOP;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else
      case (r_state)
        IDLE: r_state <= REQ;
        REQ:
          if (im_gnt_i) begin
            r_pc    <= pc_in;
            r_state <= WAIT;
          end
        WAIT:
          if (im_rvalid_i || w_to) begin
            r_instr <= im_rvalid_i ? im_rdata_i : NOP;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        HOLD:
          if (!pipe_stall_i) begin
            r_valid <= 1'b0;
            r_state <= REQ;
          end
      endcase
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus a randomized run scored against a program-flow model of fetch order.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] pc_in = RST_PC, im_rdata_i = '0, target = '0;
  logic        redirect_i = 1'b0, pipe_stall_i = 1'b0, im_gnt_i = 1'b0, im_rvalid_i = 1'b0;
  logic        im_req_o, instr_valid_o, pc_hold_o, pc_load_o, redirect_ack_o, fetch_err_o;
  logic [31:0] im_addr_o, instr_o, pc_o;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .redirect_i(redirect_i), .pipe_stall_i(pipe_stall_i),
    .im_req_o(im_req_o), .im_addr_o(im_addr_o), .im_gnt_i(im_gnt_i), .im_rvalid_i(im_rvalid_i),
    .im_rdata_i(im_rdata_i), .instr_o(instr_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
    .pc_hold_o(pc_hold_o), .pc_load_o(pc_load_o), .redirect_ack_o(redirect_ack_o), .fetch_err_o(fetch_err_o)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Models the PC register around the DUT: hold beats load, otherwise +4.
  task automatic tick();
    logic [31:0] np;
    #1;
    np = reset ? RST_PC : pc_hold_o ? pc_in : pc_load_o ? target : pc_in + 32'd4;
    @(posedge clk);
    #1 pc_in = np;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; im_gnt_i = 0; im_rvalid_i = 0; pipe_stall_i = 0; redirect_i = 0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_i = 1'b1; im_gnt_i = 1'b1; im_rvalid_i = 1'b1;
    tick(); #1;
    tests++; if ({im_req_o, instr_valid_o, fetch_err_o, redirect_ack_o, pc_hold_o} !== 5'b00001) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00001", {im_req_o, instr_valid_o, fetch_err_o, redirect_ack_o, pc_hold_o}); end
    tests++; if ({instr_o, pc_o} !== {32'h0, RST_PC}) begin
      fails++; $display("FAIL reset_data: got %h/%h want 0/%h", instr_o, pc_o, RST_PC); end
    redirect_i = 0; im_gnt_i = 0; im_rvalid_i = 0; reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    tests++; if ({im_req_o, im_addr_o} !== {1'b1, RST_PC}) begin
      fails++; $display("FAIL first_req: got %b/%h want 1/%h", im_req_o, im_addr_o, RST_PC); end
    im_gnt_i = 1'b1; #1;
    tests++; if (pc_hold_o !== 1'b0) begin fails++; $display("FAIL gnt_hold: got %b want 0", pc_hold_o); end
    tick(); im_gnt_i = 0;
    tests++; if ({pc_o, im_req_o, instr_valid_o, pc_hold_o} !== {RST_PC, 3'b001}) begin
      fails++; $display("FAIL wait_state: got %h/%b want %h/001", pc_o, {im_req_o, instr_valid_o, pc_hold_o}, RST_PC); end
    im_rvalid_i = 1'b1; im_rdata_i = 32'h3c01_0001; pipe_stall_i = 1'b1;
    tick(); im_rvalid_i = 0;
    tests++; if ({instr_valid_o, instr_o, pc_o} !== {1'b1, 32'h3c01_0001, RST_PC}) begin
      fails++; $display("FAIL first_instr: got %b/%h/%h want 1/3c010001/%h", instr_valid_o, instr_o, pc_o, RST_PC); end
    pipe_stall_i = 0;
    tick();
    tests++; if ({im_req_o, instr_valid_o, im_addr_o} !== {2'b10, 32'h3004}) begin
      fails++; $display("FAIL next_addr: got %b/%h want 10/00003004", {im_req_o, instr_valid_o}, im_addr_o); end
  endtask

  task automatic test_gnt_delay();
    pc_in = 32'h3008;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if ({im_req_o, pc_hold_o, im_addr_o} !== {2'b11, 32'h3008}) begin
        fails++; $display("FAIL gnt_delay_%0d: got %b/%h want 11/00003008", i, {im_req_o, pc_hold_o}, im_addr_o); end
      tick();
    end
    im_gnt_i = 1'b1; #1;
    tests++; if (pc_hold_o !== 1'b0) begin fails++; $display("FAIL late_gnt_hold: got %b want 0", pc_hold_o); end
    tick(); im_gnt_i = 0;
    tests++; if ({pc_o, im_req_o} !== {32'h3008, 1'b0}) begin
      fails++; $display("FAIL late_gnt_pc: got %h/%b want 00003008/0", pc_o, im_req_o); end
  endtask

  task automatic test_stall();
    im_rvalid_i = 1'b1; im_rdata_i = 32'h2402_0005; pipe_stall_i = 1'b1;
    tick(); im_rvalid_i = 0; im_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tests++; if ({instr_valid_o, instr_o, pc_o, im_req_o} !== {1'b1, 32'h2402_0005, 32'h3008, 1'b0}) begin
        fails++; $display("FAIL stall_%0d: got %b/%h/%h/%b want 1/24020005/00003008/0", i, instr_valid_o, instr_o, pc_o, im_req_o); end
      tick();
    end
    pipe_stall_i = 0;
    tick();
    tests++; if ({instr_valid_o, im_req_o} !== 2'b01) begin
      fails++; $display("FAIL stall_release: got %b want 01", {instr_valid_o, im_req_o}); end
  endtask

  task automatic test_redirect();
    pc_in = 32'h3010; target = 32'h5000; redirect_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if ({redirect_ack_o, pc_load_o, pc_hold_o} !== 3'b001) begin
        fails++; $display("FAIL redir_wait_%0d: got %b want 001", i, {redirect_ack_o, pc_load_o, pc_hold_o}); end
      tick();
    end
    im_gnt_i = 1'b1; #1;
    tests++; if ({redirect_ack_o, pc_load_o, pc_hold_o} !== 3'b110) begin
      fails++; $display("FAIL redir_ack: got %b want 110", {redirect_ack_o, pc_load_o, pc_hold_o}); end
    tick(); im_gnt_i = 0; redirect_i = 0;
    im_rvalid_i = 1'b1; im_rdata_i = 32'h2108_0001;
    tick(); im_rvalid_i = 0;
    tests++; if ({instr_valid_o, instr_o, pc_o} !== {1'b1, 32'h2108_0001, 32'h3010}) begin
      fails++; $display("FAIL delay_slot: got %b/%h/%h want 1/21080001/00003010", instr_valid_o, instr_o, pc_o); end
    tick();
    tests++; if ({im_req_o, im_addr_o} !== {1'b1, 32'h5000}) begin
      fails++; $display("FAIL redir_target: got %b/%h want 1/00005000", im_req_o, im_addr_o); end
  endtask

  task automatic test_reset_mid();
    im_gnt_i = 1'b1; tick(); im_gnt_i = 0;
    reset = 1'b1; #1;
    tests++; if ({im_req_o, instr_valid_o, pc_o} !== {2'b00, RST_PC}) begin
      fails++; $display("FAIL async_reset: got %b/%h want 00/%h", {im_req_o, instr_valid_o}, pc_o, RST_PC); end
    tick(); reset = 0;
    im_rvalid_i = 1'b1; im_rdata_i = 32'hDEAD_BEEF;
    tick(); im_rvalid_i = 0;
    tests++; if ({im_req_o, instr_valid_o, instr_o} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL late_rvalid: got %b/%h want 10/00000000", {im_req_o, instr_valid_o}, instr_o); end
  endtask

  task automatic test_timeout();
    im_gnt_i = 1'b1; tick(); im_gnt_i = 0;
`ifdef FETCH_TIMEOUT_EN
    repeat (254) tick();
    tests++; if ({instr_valid_o, fetch_err_o} !== 2'b00) begin
      fails++; $display("FAIL pre_timeout: got %b want 00", {instr_valid_o, fetch_err_o}); end
    tick();
    tests++; if ({fetch_err_o, instr_valid_o, instr_o} !== {2'b11, 32'h0}) begin
      fails++; $display("FAIL timeout: got %b/%h want 11/00000000", {fetch_err_o, instr_valid_o}, instr_o); end
    pipe_stall_i = 1'b1; im_rvalid_i = 1'b1; im_rdata_i = 32'hFFFF_FFFF;
    tick(); im_rvalid_i = 0; pipe_stall_i = 0;
    tick();
    tests++; if ({fetch_err_o, instr_valid_o, instr_o} !== {2'b10, 32'h0}) begin
      fails++; $display("FAIL stray_rvalid: got %b/%h want 10/00000000", {fetch_err_o, instr_valid_o}, instr_o); end
`else
    repeat (300) tick();
    tests++; if ({im_req_o, instr_valid_o, fetch_err_o} !== 3'b000) begin
      fails++; $display("FAIL long_wait: got %b want 000", {im_req_o, instr_valid_o, fetch_err_o}); end
    im_rvalid_i = 1'b1; im_rdata_i = 32'h1234_5678;
    tick(); im_rvalid_i = 0;
    tests++; if ({instr_valid_o, instr_o, fetch_err_o} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      fails++; $display("FAIL slow_rvalid: got %b/%h/%b want 1/12345678/0", instr_valid_o, instr_o, fetch_err_o); end
    tick();
`endif
  endtask

  // Program-order model: each consumed instruction must be the next address of the program flow,
  // where a branch is followed by its delay slot and then its target.
  task automatic test_random();
    logic [31:0] exp_next, pend_addr, prev_instr, prev_pc;
    logic pend, slot_next, redir_active, was_stalled, exp_ack;
    int consumed;
    do_reset();
    exp_next = RST_PC; pend = 0; slot_next = 0; redir_active = 0; was_stalled = 0; consumed = 0;
    prev_instr = '0; prev_pc = '0;
    for (int c = 0; c < 4000; c++) begin
      im_gnt_i     = im_req_o && ($urandom_range(0, 2) == 0);
      im_rvalid_i  = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      im_rdata_i   = (im_rvalid_i && pend) ? mem(pend_addr) : $urandom;
      pipe_stall_i = ($urandom_range(0, 2) == 0);
      redirect_i   = redir_active;
      #1;
      exp_ack = redirect_i && (!im_req_o || im_gnt_i);
      tests++; if ({redirect_ack_o, pc_load_o, pc_hold_o} !== {exp_ack, exp_ack, !(exp_ack || (im_req_o && im_gnt_i))}) begin
        fails++; $display("FAIL rnd_ctrl cyc %0d: got %b want %b", c, {redirect_ack_o, pc_load_o, pc_hold_o},
                          {exp_ack, exp_ack, !(exp_ack || (im_req_o && im_gnt_i))}); end
      if (redirect_ack_o) redir_active = 0;
      if (im_rvalid_i && pend) pend = 0;
      if (im_req_o && im_gnt_i) begin pend = 1; pend_addr = im_addr_o; end
      if (was_stalled) begin
        tests++; if ({instr_valid_o, instr_o, pc_o} !== {1'b1, prev_instr, prev_pc}) begin
          fails++; $display("FAIL rnd_stable cyc %0d: got %b/%h/%h want 1/%h/%h", c, instr_valid_o, instr_o, pc_o, prev_instr, prev_pc); end
      end
      was_stalled = instr_valid_o && pipe_stall_i;
      prev_instr = instr_o; prev_pc = pc_o;
      if (instr_valid_o && !pipe_stall_i) begin
        consumed++;
        tests++; if ({pc_o, instr_o, redir_active} !== {exp_next, mem(exp_next), 1'b0}) begin
          fails++; $display("FAIL rnd_order cyc %0d: got %h/%h/%b want %h/%h/0", c, pc_o, instr_o, redir_active, exp_next, mem(exp_next)); end
        if (slot_next) begin
          exp_next = target; slot_next = 0;
        end else begin
          exp_next = exp_next + 32'd4;
          if ($urandom_range(0, 3) == 0) begin
            slot_next = 1; redir_active = 1;
            target = 32'h4000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          end
        end
      end
      tick();
    end
    tests++; if (consumed < 200) begin fails++; $display("FAIL rnd_progress: got %0d want >=200", consumed); end
    im_gnt_i = 0; im_rvalid_i = 0; redirect_i = 0; pipe_stall_i = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_gnt_delay();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch from a variable-latency, single-port instruction memory (req/gnt/rvalid handshake) and drives the PC register's hold and load controls. It buffers one fetched instruction for the ID stage and applies ID-resolved branch redirects only after the delay-slot fetch has been granted, so MIPS delay-slot semantics are preserved. Sits between the PC register, the instruction memory and the IF/ID boundary.

Parameters:
RESET_PC, 32'h00003000, PC reported on pc_o after reset
TIMEOUT_CYCLES, 255, max WAIT cycles before fetch error (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
pc_in  in  32  current PC register value
redirect_i  in  1  taken branch/jump from ID; held high, target stable, until redirect_ack_o
pipe_stall_i  in  1  ID cannot accept an instruction this cycle
im_req_o  out  1  memory request
im_addr_o  out  32  request address = {pc_in[31:2],2'b00}
im_gnt_i  in  1  request accepted this cycle
im_rvalid_i  in  1  read data valid
im_rdata_i  in  32  read data
instr_o  out  32  buffered instruction to ID
pc_o  out  32  address of instr_o
instr_valid_o  out  1  instr_o is valid
pc_hold_o  out  1  PC register stall (has priority over pc_load_o in PC register)
pc_load_o  out  1  PC register loads branch target (equals redirect_ack_o)
redirect_ack_o  out  1  one-cycle redirect acceptance
fetch_err_o  out  1  sticky timeout flag (0 when feature off)

Behaviour:
- Reset (async): state IDLE; im_req_o=0, instr_valid_o=0, instr_o=0, pc_o=RESET_PC, fetch_err_o=0, redirect_ack_o=0; pc_hold_o=1.
- States IDLE, REQ, WAIT, HOLD. One outstanding request max.
- IDLE: first clock after reset deasserts -> REQ. rvalid/gnt ignored.
- REQ: im_req_o=1, im_addr_o from pc_in combinationally (address may change before grant). On im_gnt_i: latch pc_in into pc_o register, -> WAIT. rvalid in REQ ignored.
- WAIT: im_req_o=0. On im_rvalid_i: instr_o<=im_rdata_i, instr_valid_o<=1, -> HOLD.
- HOLD: instr_valid_o=1; instr_o/pc_o stable while pipe_stall_i=1. When pipe_stall_i=0 the instruction is consumed: instr_valid_o<=0, -> REQ. Min 3 cycles per instruction (gnt same cycle, rvalid next cycle).
- PC advance: pc_hold_o=0 exactly in cycles where (state==REQ && im_gnt_i) or redirect_ack_o; otherwise 1. Advancing at grant makes PC = granted+4 during WAIT/HOLD.
- Redirect: redirect_ack_o = redirect_i && (state==WAIT || state==HOLD || (state==REQ && im_gnt_i)). Never acked in IDLE or ungranted REQ, so the delay slot is fetched first. pc_load_o=redirect_ack_o. Ack with grant in same cycle: PC loads target (not +4). In-flight/buffered instruction is never discarded.
- Next request after an ack uses pc_in = target.
- Reset mid-operation: immediate return to IDLE; a late rvalid after reset is ignored.

Optional Feature:
FETCH_TIMEOUT_EN. Defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle without rvalid. On reaching TIMEOUT_CYCLES: fetch_err_o<=1 (sticky until reset), instr_o<=32'h00000000 (NOP), instr_valid_o<=1, -> HOLD. A later stray rvalid is ignored. Undefined: no counter; fetch_err_o tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package/include fetch_pkg: state encodings (IDLE, REQ, WAIT, HOLD), RESET_PC default, NOP constant 32'h0.
- One sub-module, fetch_timeout_ctr (counter + compare), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset then gnt same cycle, rvalid next cycle, data 32'h3c010001 -> instr_o=32'h3c010001, pc_o=32'h3000, valid in cycle 3; pc_hold_o low only on gnt cycle; next im_addr_o=32'h3004.
- gnt delayed 4 cycles with pc_in stable at 32'h3008 -> im_req_o held 4 cycles, pc_hold_o stays 1 until grant.
- HOLD with pipe_stall_i high 5 cycles -> instr_o/pc_o/instr_valid_o unchanged, no new request; drops 1 cycle after stall clears.
- redirect_i raised while REQ for delay slot 32'h3010 ungranted -> no ack until gnt; ack, pc_load_o=1, pc_hold_o=0 on gnt cycle; slot instr delivered; next fetch at target.
- Async reset asserted during WAIT, rvalid arrives after release -> state IDLE, rvalid ignored, instr_valid_o=0.
- (FETCH_TIMEOUT_EN) no rvalid for 255 WAIT cycles -> fetch_err_o=1, instr_o=32'h0, instr_valid_o=1.
